instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 29 ++
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: request fields in, encoded word out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs fields + immediate per format, range-checks,
// and buffers {instr, err} in a 2-entry FIFO.
module instr_encoder (
    input  logic               clk,
    input  logic               rst,
    instr_encoder_if.slave     bus,
    output logic [15:0]        enc_count,
    output logic [15:0]        err_count
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
        FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
    } fmt_e;

    logic [63:0] imm;
    logic        i_ok, b_ok, j_ok, u_ok;
    logic [31:0] enc_instr;
    logic        enc_err;

    assign imm  = bus.in_imm;
    // Each range check is "upper bits are a pure sign extension".
    assign i_ok = (&imm[63:11]) | ~(|imm[63:11]);
    assign b_ok = ((&imm[63:12]) | ~(|imm[63:12])) & ~imm[0];
    assign j_ok = ((&imm[63:20]) | ~(|imm[63:20])) & ~imm[0];
    assign u_ok = ~(|imm[11:0]) & ((&imm[63:31]) | ~(|imm[63:31]));

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (fmt_e'(bus.in_fmt))
            FMT_R: enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_rd, bus.in_opcode};
            FMT_I: begin
                enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                enc_err   = ~i_ok;
            end
            FMT_S: begin
                enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:0], bus.in_opcode};
                enc_err   = ~i_ok;
            end
            FMT_B: begin
                enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:1], imm[11], bus.in_opcode};
                enc_err   = ~b_ok;
            end
            FMT_U: begin
                enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
                enc_err   = ~u_ok;
            end
            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
                enc_err   = ~j_ok;
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) enc_instr = '0;
    end

    logic [32:0] mem_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  occ_q, occ_d;
    logic        rdy_q;
    logic [15:0] enc_cnt_q, err_cnt_q;
    logic        push, pop;

    assign push = bus.in_valid & rdy_q;
    assign pop  = bus.out_ready & (occ_q != 2'd0);

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Ready is registered from next occupancy, so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            occ_q     <= 2'd0;
            rdy_q     <= 1'b0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= {enc_instr, enc_err};
                wptr_q        <= ~wptr_q;
                if (!enc_err && enc_cnt_q != 16'hFFFF) enc_cnt_q <= enc_cnt_q + 16'd1;
                if (enc_err && err_cnt_q != 16'hFFFF)  err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (pop) rptr_q <= ~rptr_q;
            occ_q <= occ_d;
            rdy_q <= (occ_d != 2'd2);
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (occ_q != 2'd0);
    assign {bus.out_instr, bus.out_err} = (occ_q != 2'd0) ? mem_q[rptr_q] : 33'd0;
    assign enc_count = enc_cnt_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, backpressure, random round trip, reset mid-stream.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] enc_count, err_count;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic rt;
        vec_t v;
    } sb_t;

    sb_t  sb [$];
    vec_t tbl [$];
    int   total = 0;
    int   bad   = 0;
    int   n_good = 0;
    int   n_err  = 0;

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    // Standard RV32 immediate decoder, independent of the encoder's packing.
    function automatic logic [63:0] dec_imm(input logic [2:0] fmt, input logic [31:0] w);
        logic [31:0] x;
        case (fmt)
            3'd1:    x = {{20{w[31]}}, w[31:20]};
            3'd2:    x = {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    x = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    x = {w[31:12], 12'b0};
            3'd5:    x = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: x = 32'd0;
        endcase
        return {{32{x[31]}}, x};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v, input logic rt);
        int tries = 0;
        bus.in_fmt = v.fmt; bus.in_opcode = v.op; bus.in_rd = v.rd; bus.in_rs1 = v.rs1;
        bus.in_rs2 = v.rs2; bus.in_funct3 = v.f3; bus.in_funct7 = v.f7; bus.in_imm = v.imm;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && tries < 50) begin
            if (rt) bus.out_ready = 1'b1;
            @(posedge clk); #1;
            tries++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", tries);
            bus.in_valid = 1'b0;
            return;
        end
        sb.push_back('{rt: rt, v: v});
        if (rt || !v.exp_err) n_good++; else n_err++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    // Scoreboard: compare the head entry whenever a transfer will happen at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            sb_t e;
            logic ok;
            logic [31:0] w;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got %h err=%b with nothing expected", bus.out_instr, bus.out_err);
            end else begin
                e = sb.pop_front();
                w = bus.out_instr;
                if (!e.rt) begin
                    if (w !== e.v.exp_instr || bus.out_err !== e.v.exp_err) begin
                        bad++;
                        $display("FAIL vec_out: got %h err=%b expected %h err=%b",
                                 w, bus.out_err, e.v.exp_instr, e.v.exp_err);
                    end
                end else begin
                    ok = (bus.out_err === 1'b0) && (w[6:0] == e.v.op);
                    if (e.v.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) ok = ok && (w[11:7] == e.v.rd);
                    if (e.v.fmt inside {3'd0, 3'd1, 3'd2, 3'd3})
                        ok = ok && (w[19:15] == e.v.rs1) && (w[14:12] == e.v.f3);
                    if (e.v.fmt inside {3'd0, 3'd2, 3'd3}) ok = ok && (w[24:20] == e.v.rs2);
                    if (e.v.fmt == 3'd0) ok = ok && (w[31:25] == e.v.f7);
                    else ok = ok && (dec_imm(e.v.fmt, w) == e.v.imm);
                    if (!ok) begin
                        bad++;
                        $display("FAIL roundtrip fmt=%0d: got %h err=%b decoded imm %h expected imm %h",
                                 e.v.fmt, w, bus.out_err, dec_imm(e.v.fmt, w), e.v.imm);
                    end
                end
            end
        end
    end

    initial begin
        vec_t va, vb, vc, vr;
        int   r;

        tbl.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1,       32'hFFF00093, 1'b0));
        tbl.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd4,       32'hFE208EE3, 1'b0));
        tbl.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3,         32'h0,        1'b1));
        tbl.push_back(mk(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 64'h123,      32'h405201B3, 1'b0));
        tbl.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'd8,         32'h0020A423, 1'b0));
        tbl.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000,  32'h123452B7, 1'b0));
        tbl.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345001,  32'h0,        1'b1));
        tbl.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h80000000,  32'h0,        1'b1));
        tbl.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFFFFFF80000000, 32'h800002B7, 1'b0));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048,      32'h001000EF, 1'b0));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1048576, 32'h800000EF, 1'b0));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1048574,   32'h7FFFF0EF, 1'b0));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1048576,   32'h0,        1'b1));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1,         32'h0,        1'b1));
        tbl.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2047,      32'h7FF00093, 1'b0));
        tbl.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048,      32'h0,        1'b1));
        tbl.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2048,    32'h80000093, 1'b0));
        tbl.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd4094,      32'h7E208FE3, 1'b0));
        tbl.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd4096,      32'h0,        1'b1));
        tbl.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd4096,    32'h80208063, 1'b0));
        tbl.push_back(mk(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0,         32'h0,        1'b1));
        tbl.push_back(mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0,         32'h0,        1'b1));
        tbl.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -64'sd2049,    32'h0,        1'b1));

        va = mk(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd100, 32'h06400113, 1'b0);
        vb = mk(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'd200, 32'h0C800193, 1'b0);
        vc = mk(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 64'd300, 32'h12C00213, 1'b0);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_out_err",   64'(bus.out_err),   64'd0);
        chk("rst_enc_count", 64'(enc_count),     64'd0);
        chk("rst_err_count", 64'(err_count),     64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // First request: must be visible the cycle after acceptance.
        bus.out_ready = 1'b0;
        send(tbl[0], 1'b0);
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_out_instr", 64'(bus.out_instr), 64'hFFF00093);
        chk("lat_enc_count", 64'(enc_count),     64'd1);
        bus.out_ready = 1'b1;
        for (int i = 1; i < tbl.size(); i++) send(tbl[i], 1'b0);
        drain();
        chk("tbl_enc_count", 64'(enc_count), 64'(n_good));
        chk("tbl_err_count", 64'(err_count), 64'(n_err));

        // Backpressure: two accepts fill the FIFO, the third stalls with head held stable.
        bus.out_ready = 1'b0;
        send(va, 1'b0);
        send(vb, 1'b0);
        chk("bp_ready_full", 64'(bus.in_ready), 64'd0);
        bus.in_fmt = vc.fmt; bus.in_rd = vc.rd; bus.in_imm = vc.imm; bus.in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_stall_ready", 64'(bus.in_ready),  64'd0);
            chk("bp_hold_instr",  64'(bus.out_instr), 64'h06400113);
        end
        bus.out_ready = 1'b1;
        send(vc, 1'b0);
        drain();

        // Random legal round trip through a standard immediate decoder.
        for (int k = 0; k < 60; k++) begin
            vr.fmt = 3'($urandom_range(0, 5));
            vr.op  = 7'($urandom); vr.rd = 5'($urandom); vr.rs1 = 5'($urandom);
            vr.rs2 = 5'($urandom); vr.f3 = 3'($urandom); vr.f7 = 7'($urandom);
            case (vr.fmt)
                3'd1, 3'd2: r = int'($urandom_range(0, 4095)) - 2048;
                3'd3:       r = (int'($urandom_range(0, 4095)) - 2048) * 2;
                3'd4:       r = int'($urandom) & 32'hFFFFF000;
                3'd5:       r = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                default:    r = int'($urandom);
            endcase
            vr.imm = {{32{r[31]}}, r[31:0]};
            if (vr.fmt == 3'd0) vr.imm = {32'($urandom), 32'($urandom)};
            vr.exp_instr = '0; vr.exp_err = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            send(vr, 1'b1);
        end
        drain();

        // Reset with two entries buffered: nothing stale may come out afterwards.
        bus.out_ready = 1'b0;
        send(va, 1'b0);
        send(vb, 1'b0);
        chk("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        n_good = 0; n_err = 0;
        chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_enc_count", 64'(enc_count),     64'd0);
        chk("mid_err_count", 64'(err_count),     64'd0);
        chk("mid_in_ready0", 64'(bus.in_ready),  64'd0);
        chk("mid_out_instr", 64'(bus.out_instr), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_in_ready1", 64'(bus.in_ready),  64'd1);
        chk("mid_no_stale",  64'(bus.out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_stale2", 64'(bus.out_valid), 64'd0);
        send(vc, 1'b0);
        drain();
        chk("post_enc_count", 64'(enc_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
